// File: rtl/axi_lite_apb_bridge.sv
`default_nettype none
// ============================================================================
// axi_lite_apb_bridge : AXI-Lite slave to single APB master, one transfer at a
// time. Optional macro APB_TIMEOUT_EN aborts a stalled ACCESS.  Rev 1.0
// ============================================================================
module axi_lite_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [2:0]              aw_prot_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [2:0]              ar_prot_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  output logic                    busy_o
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_SETUP  = 3'd1;
  localparam logic [2:0] c_ACCESS = 3'd2;
  localparam logic [2:0] c_WRESP  = 3'd3;
  localparam logic [2:0] c_RRESP  = 3'd4;

  localparam logic       c_GRANT_WRITE = 1'b0;
  localparam logic       c_GRANT_READ  = 1'b1;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  if (ADDR_WIDTH != 32 || DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_lite_apb_bridge: only 32-bit address/data and TIMEOUT_CYCLES >= 1 are supported");
  end

  logic [2:0]              r_state;
  logic                    r_last_grant;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [2:0]              r_pprot;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic [1:0]              r_b_resp;
  logic                    r_b_valid;
  logic [DATA_WIDTH-1:0]   r_r_data;
  logic [1:0]              r_r_resp;
  logic                    r_r_valid;

  logic                    w_in_idle;
  logic                    w_wr_pend;
  logic                    w_rd_pend;
  logic                    w_wr_grant;
  logic                    w_rd_grant;
  logic                    w_xfer_done;
  logic [1:0]              w_xfer_resp;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  // Grants are combinational so the handshake lands in the IDLE cycle itself;
  // gating with rst_ni keeps every ready low while reset is held.
  assign w_in_idle  = (r_state == c_IDLE) & rst_ni;
  assign w_wr_pend  = aw_valid_i & w_valid_i;
  assign w_rd_pend  = ar_valid_i;
  assign w_wr_grant = w_in_idle & w_wr_pend & (~w_rd_pend | (r_last_grant == c_GRANT_READ));
  assign w_rd_grant = w_in_idle & w_rd_pend & ~w_wr_grant;

`ifdef APB_TIMEOUT_EN
  localparam int                    c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] c_TMO_DATA = DATA_WIDTH'(32'hDEADBEEF);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (r_state == c_SETUP) begin
      r_tmo_cnt <= '0;
    end else if (r_state == c_ACCESS && !pready_i) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Abort on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  assign w_timeout   = (r_state == c_ACCESS) & ~pready_i &
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_xfer_done = pready_i | w_timeout;
  assign w_xfer_resp = (w_timeout | pslverr_i) ? c_RESP_SLVERR : c_RESP_OKAY;
  assign w_rd_data   = w_timeout ? c_TMO_DATA : prdata_i;
`else
  assign w_xfer_done = pready_i;
  assign w_xfer_resp = pslverr_i ? c_RESP_SLVERR : c_RESP_OKAY;
  assign w_rd_data   = prdata_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= c_IDLE;
      r_last_grant <= c_GRANT_READ;
      r_paddr      <= '0;
      r_pprot      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_b_resp     <= c_RESP_OKAY;
      r_b_valid    <= 1'b0;
      r_r_data     <= '0;
      r_r_resp     <= c_RESP_OKAY;
      r_r_valid    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_wr_grant) begin
            r_paddr      <= aw_addr_i;
            r_pprot      <= aw_prot_i;
            r_pwdata     <= w_data_i;
            r_pstrb      <= w_strb_i;
            r_pwrite     <= 1'b1;
            r_psel       <= 1'b1;
            r_last_grant <= c_GRANT_WRITE;
            r_state      <= c_SETUP;
          end else if (w_rd_grant) begin
            r_paddr      <= ar_addr_i;
            r_pprot      <= ar_prot_i;
            r_pstrb      <= '0;
            r_pwrite     <= 1'b0;
            r_psel       <= 1'b1;
            r_last_grant <= c_GRANT_READ;
            r_state      <= c_SETUP;
          end
        end
        c_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= c_ACCESS;
        end
        c_ACCESS: begin
          if (w_xfer_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (r_pwrite) begin
              r_b_resp  <= w_xfer_resp;
              r_b_valid <= 1'b1;
              r_state   <= c_WRESP;
            end else begin
              r_r_data  <= w_rd_data;
              r_r_resp  <= w_xfer_resp;
              r_r_valid <= 1'b1;
              r_state   <= c_RRESP;
            end
          end
        end
        c_WRESP: begin
          if (b_ready_i) begin
            r_b_valid <= 1'b0;
            r_state   <= c_IDLE;
          end
        end
        c_RRESP: begin
          if (r_ready_i) begin
            r_r_valid <= 1'b0;
            r_state   <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign aw_ready_o = w_wr_grant;
  assign w_ready_o  = w_wr_grant;
  assign ar_ready_o = w_rd_grant;
  assign b_resp_o   = r_b_resp;
  assign b_valid_o  = r_b_valid;
  assign r_data_o   = r_r_data;
  assign r_resp_o   = r_r_resp;
  assign r_valid_o  = r_r_valid;
  assign paddr_o    = r_paddr;
  assign pprot_o    = r_pprot;
  assign psel_o     = r_psel;
  assign penable_o  = r_penable;
  assign pwrite_o   = r_pwrite;
  assign pwdata_o   = r_pwdata;
  assign pstrb_o    = r_pstrb;
  assign busy_o     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_apb_bridge.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_apb_bridge : directed self-checking bench for axi_lite_apb_bridge
// with a behavioural APB slave.  Rev 1.0
// ============================================================================
module tb_axi_lite_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] aw_addr = '0;
  logic [2:0]  aw_prot = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [31:0] ar_addr = '0;
  logic [2:0]  ar_prot = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  axi_lite_apb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .aw_addr_i  (aw_addr),
    .aw_prot_i  (aw_prot),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .b_resp_o   (b_resp),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .ar_addr_i  (ar_addr),
    .ar_prot_i  (ar_prot),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .r_data_o   (r_data),
    .r_resp_o   (r_resp),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .paddr_o    (paddr),
    .pprot_o    (pprot),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .pstrb_o    (pstrb),
    .prdata_i   (prdata),
    .pready_i   (pready),
    .pslverr_i  (pslverr),
    .busy_o     (busy)
  );

  // APB slave: configured by the stimulus process, observed through running totals.
  int          wait_states = 0;
  logic        err_next    = 1'b0;
  logic [31:0] rdata_next  = '0;
  int          acc_total   = 0;
  int          setup_total = 0;
  int          moved_total = 0;
  int          wcnt        = 0;
  logic [31:0] seen_addr   = '0;
  logic [31:0] seen_wdata  = '0;
  logic [3:0]  seen_strb   = '0;
  logic [2:0]  seen_prot   = '0;
  logic        seen_pwrite = 1'b0;

  always @(negedge clk) begin
    if (psel && penable) begin
      acc_total++;
      if (paddr !== seen_addr || pwrite !== seen_pwrite || pwdata !== seen_wdata ||
          pstrb !== seen_strb || pprot !== seen_prot)
        moved_total++;
      pready  = (wcnt >= wait_states);
      pslverr = pready & err_next;
      prdata  = pready ? rdata_next : 32'h0;
      wcnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      wcnt    = 0;
      if (psel) begin
        setup_total++;
        seen_addr   = paddr;
        seen_pwrite = pwrite;
        seen_wdata  = pwdata;
        seen_strb   = pstrb;
        seen_prot   = pprot;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at negedge+1; returns once the response handshake has completed.
  task automatic wait_resp(input logic is_wr, input int hold, input int start,
                           output logic [1:0] resp, output logic [31:0] data, output int lat);
    int n;
    int viol;
    n = start;
    while (!(is_wr ? b_valid : r_valid) && n < 600) begin
      @(negedge clk); #1;
      n++;
    end
    if (is_wr) check_value("b_valid_rise", 32'(b_valid), 32'd1);
    else       check_value("r_valid_rise", 32'(r_valid), 32'd1);
    lat  = n;
    resp = is_wr ? b_resp : r_resp;
    data = r_data;
    viol = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (is_wr && (!b_valid || b_resp !== resp)) viol++;
      if (!is_wr && (!r_valid || r_resp !== resp || r_data !== data)) viol++;
      if (psel || ar_ready || aw_ready) viol++;
    end
    if (hold > 0) check_value("resp_hold_stable", 32'(viol), 32'd0);
    if (is_wr) b_ready = 1'b1;
    else       r_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    r_ready = 1'b0;
    #1;
    if (is_wr) check_value("b_valid_clear", 32'(b_valid), 32'd0);
    else       check_value("r_valid_clear", 32'(r_valid), 32'd0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold, input logic raise_ar,
                           output logic [1:0] resp, output int lat);
    int n;
    logic [31:0] unused_data;
    @(negedge clk);
    aw_addr  = addr;
    aw_prot  = 3'b010;
    w_data   = data;
    w_strb   = strb;
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    n = 0;
    #1;
    while (!(aw_ready && w_ready) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check_value("wr_accept", 32'(aw_ready && w_ready), 32'd1);
    @(negedge clk);
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    if (raise_ar) ar_valid = 1'b1;
    #1;
    wait_resp(1'b1, hold, 1, resp, unused_data, lat);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int hold,
                          output logic [1:0] resp, output logic [31:0] data, output int lat);
    int n;
    @(negedge clk);
    ar_addr  = addr;
    ar_prot  = 3'b001;
    ar_valid = 1'b1;
    n = 0;
    #1;
    while (!ar_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check_value("rd_accept", 32'(ar_ready), 32'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    #1;
    wait_resp(1'b0, hold, 1, resp, data, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    int          s0, a0, m0;
    int          grants, both, viol;
    logic [3:0]  pat;

    // Reset state, with requests already presented: nothing may be accepted.
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    ar_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_value("rst_readies", {29'd0, aw_ready, w_ready, ar_ready}, 32'd0);
    check_value("rst_valids",  {30'd0, b_valid, r_valid}, 32'd0);
    check_value("rst_apb_ctl", {28'd0, psel, penable, pwrite, busy}, 32'd0);
    check_value("rst_paddr",   paddr, 32'd0);
    check_value("rst_pwdata",  pwdata, 32'd0);
    check_value("rst_rdata",   r_data, 32'd0);
    check_value("rst_resps",   {25'd0, pprot, b_resp, r_resp}, 32'd0);
    check_value("rst_pstrb",   {28'd0, pstrb}, 32'd0);
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    ar_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All three channels pending right after reset: write first, then alternate.
    @(negedge clk);
    aw_addr  = 32'h1A10_0010;
    w_data   = 32'hA5A5_0001;
    w_strb   = 4'hF;
    ar_addr  = 32'h1A10_0020;
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    ar_valid = 1'b1;
    b_ready  = 1'b1;
    r_ready  = 1'b1;
    grants = 0;
    both   = 0;
    pat    = 4'b0;
    for (int c = 0; c < 80 && grants < 4; c++) begin
      #1;
      if (aw_ready && ar_ready) both++;
      if (aw_ready) begin
        pat = {pat[2:0], 1'b1};
        grants++;
      end else if (ar_ready) begin
        pat = {pat[2:0], 1'b0};
        grants++;
      end
      @(negedge clk);
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    ar_valid = 1'b0;
    #1;
    for (int c = 0; c < 20 && busy; c++) begin
      @(negedge clk); #1;
    end
    b_ready = 1'b0;
    r_ready = 1'b0;
    check_value("rr_grant_count", 32'(grants), 32'd4);
    check_value("rr_order_WRWR", {28'd0, pat}, 32'h0000_000A);
    check_value("rr_no_dual_grant", 32'(both), 32'd0);
    check_value("rr_drained", 32'(busy), 32'd0);

    // Zero-wait write: response three cycles after acceptance.
    wait_states = 0;
    err_next    = 1'b0;
    s0 = setup_total; a0 = acc_total; m0 = moved_total;
    write_txn(32'h1A10_0004, 32'h1234_5678, 4'hF, 0, 1'b0, resp, lat);
    check_value("wr_resp", {30'd0, resp}, 32'd0);
    check_value("wr_latency", 32'(lat), 32'd3);
    check_value("wr_setup_cycles", 32'(setup_total - s0), 32'd1);
    check_value("wr_access_cycles", 32'(acc_total - a0), 32'd1);
    check_value("wr_apb_stable", 32'(moved_total - m0), 32'd0);
    check_value("wr_paddr", seen_addr, 32'h1A10_0004);
    check_value("wr_pwdata", seen_wdata, 32'h1234_5678);
    check_value("wr_pwrite_strb_prot", {24'd0, seen_pwrite, seen_prot, seen_strb}, 32'h0000_00AF);

    // Read with three wait states.
    wait_states = 3;
    rdata_next  = 32'hCAFE_F00D;
    s0 = setup_total; a0 = acc_total; m0 = moved_total;
    read_txn(32'h1A10_2000, 0, resp, data, lat);
    check_value("rd_data", data, 32'hCAFE_F00D);
    check_value("rd_resp", {30'd0, resp}, 32'd0);
    check_value("rd_latency", 32'(lat), 32'd6);
    check_value("rd_access_cycles", 32'(acc_total - a0), 32'd4);
    check_value("rd_apb_stable", 32'(moved_total - m0), 32'd0);
    check_value("rd_paddr", seen_addr, 32'h1A10_2000);
    check_value("rd_pwrite_strb_prot", {24'd0, seen_pwrite, seen_prot, seen_strb}, 32'h0000_0010);

    // PSLVERR on the completing cycle maps to SLVERR on both channels.
    wait_states = 1;
    err_next    = 1'b1;
    rdata_next  = 32'h0000_BEEF;
    read_txn(32'h1A10_2004, 0, resp, data, lat);
    check_value("rd_slverr", {30'd0, resp}, 32'd2);
    write_txn(32'h1A10_2008, 32'h0000_0001, 4'h1, 0, 1'b0, resp, lat);
    check_value("wr_slverr", {30'd0, resp}, 32'd2);
    err_next    = 1'b0;
    wait_states = 0;

    // AW alone must not be accepted; readies pulse together once W arrives.
    @(negedge clk);
    aw_addr  = 32'h1A10_0100;
    aw_prot  = 3'b000;
    aw_valid = 1'b1;
    w_valid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_value("aw_only_idle", {29'd0, aw_ready, w_ready, psel}, 32'd0);
      @(negedge clk);
    end
    w_data  = 32'h0BAD_CAFE;
    w_strb  = 4'h3;
    w_valid = 1'b1;
    #1;
    check_value("aw_w_joint_ready", {30'd0, aw_ready, w_ready}, 32'd3);
    @(negedge clk);
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    #1;
    wait_resp(1'b1, 0, 1, resp, data, lat);
    check_value("aw_w_resp", {30'd0, resp}, 32'd0);
    check_value("aw_w_pstrb", {28'd0, seen_strb}, 32'h3);

    // B held off for ten cycles with a read waiting behind it.
    ar_addr    = 32'h1A10_3000;
    rdata_next = 32'h5555_AAAA;
    s0 = setup_total;
    write_txn(32'h1A10_0200, 32'h7777_0000, 4'hC, 10, 1'b1, resp, lat);
    check_value("bhold_resp", {30'd0, resp}, 32'd0);
    check_value("bhold_no_apb", 32'(setup_total - s0), 32'd1);
    check_value("ar_grant_after_b", 32'(ar_ready), 32'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    #1;
    wait_resp(1'b0, 0, 1, resp, data, lat);
    check_value("bhold_rd_data", data, 32'h5555_AAAA);
    check_value("bhold_rd_addr", seen_addr, 32'h1A10_3000);

`ifdef APB_TIMEOUT_EN
    // Stuck slave: abort after TIMEOUT_CYCLES wait cycles.
    wait_states = 100000;
    a0 = acc_total;
    read_txn(32'h1A10_4000, 0, resp, data, lat);
    check_value("tmo_resp", {30'd0, resp}, 32'd2);
    check_value("tmo_data", data, 32'hDEAD_BEEF);
    check_value("tmo_access_cycles", 32'(acc_total - a0), 32'd255);
    check_value("tmo_latency", 32'(lat), 32'd257);
    wait_states = 0;
`endif

    // Reset in the middle of ACCESS drops the transfer immediately.
    wait_states = 20;
    @(negedge clk);
    ar_addr  = 32'h1A10_5000;
    ar_valid = 1'b1;
    #1;
    for (int c = 0; c < 20 && !ar_ready; c++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    ar_valid = 1'b0;
    #1;
    for (int c = 0; c < 20 && !(psel && penable); c++) begin
      @(negedge clk); #1;
    end
    check_value("mid_in_access", {30'd0, psel, penable}, 32'd3);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_apb", {29'd0, psel, penable, busy}, 32'd0);
    check_value("mid_rst_paddr", paddr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (r_valid || b_valid || psel || busy) viol++;
    end
    check_value("mid_rst_no_resp", 32'(viol), 32'd0);
    wait_states = 0;

    // Bridge is usable again after the abort.
    write_txn(32'h1A10_0300, 32'h0F0F_F0F0, 4'hF, 0, 1'b0, resp, lat);
    check_value("post_rst_resp", {30'd0, resp}, 32'd0);
    check_value("post_rst_latency", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
